// File: rtl/gcntsrc.sv
`default_nettype none
// ============================================================================
// gcntsrc : Gray-coded counter source; backlogs multi-count increments and
//           steps a registered Gray counter by at most one count per step.
// Revision : 1.0
// ============================================================================
module gcntsrc #(
  parameter int WIDTH = 16,
  parameter int INCW  = 4,
  parameter int BKLW  = 8,
  parameter int GAP   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [INCW-1:0]  inc,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] gcnt,
  output logic [WIDTH-1:0] bcnt,
  output logic [BKLW-1:0]  bklog,
  output logic             busy,
  output logic             ovf
);

  localparam int c_gapw = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam int c_sumw = BKLW + 2;
  localparam logic [c_sumw-1:0] c_bkmax = {2'b00, {BKLW{1'b1}}};
  localparam logic [c_gapw-1:0] c_gap   = c_gapw'(GAP);

  logic [WIDTH-1:0]  r_bcnt;
  logic [WIDTH-1:0]  r_gcnt;
  logic [BKLW-1:0]   r_bklog;
  logic              r_ovf;
  logic [c_gapw-1:0] r_gap;

  logic              w_step;
  logic [c_sumw-1:0] w_sum;
  logic              w_sat;
  logic [WIDTH-1:0]  w_bnext;
  logic [WIDTH-1:0]  w_gnext;

  assign w_step  = (r_bklog != '0) && (r_gap == '0);
  assign w_sum   = c_sumw'(r_bklog) + c_sumw'(inc) - c_sumw'(w_step);
  assign w_sat   = (w_sum > c_bkmax);
  assign w_bnext = r_bcnt + WIDTH'(1);
  // gcnt is derived from the next binary value and registered, so it never glitches
  assign w_gnext = w_bnext ^ (w_bnext >> 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bcnt <= '0;
      r_gcnt <= '0;
      r_gap  <= '0;
    end else if (w_step) begin
      r_bcnt <= w_bnext;
      r_gcnt <= w_gnext;
      r_gap  <= c_gap;
    end else if (r_gap != '0) begin
      r_gap  <= r_gap - c_gapw'(1);
    end
  end

  // Saturation has priority over the clear so a fresh drop is never hidden
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bklog <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_sat) begin
        r_bklog <= c_bkmax[BKLW-1:0];
        r_ovf   <= 1'b1;
      end else begin
        r_bklog <= w_sum[BKLW-1:0];
        if (ovf_clr) r_ovf <= 1'b0;
      end
    end
  end

  assign gcnt  = r_gcnt;
  assign bcnt  = r_bcnt;
  assign bklog = r_bklog;
  assign busy  = (r_bklog != '0);
  assign ovf   = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_gcntsrc.sv
`default_nettype none
// Directed and randomized bench for gcntsrc; four instances share one stimulus.
module tb_gcntsrc;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] inc = '0;
  logic ovf_clr = 1'b0;

  logic [15:0] a_gcnt, a_bcnt, c_gcnt, c_bcnt, d_gcnt, d_bcnt;
  logic [7:0]  a_bklog, c_bklog, d_bklog;
  logic [3:0]  b_gcnt, b_bcnt, b_bklog;
  logic        a_busy, a_ovf, b_busy, b_ovf, c_busy, c_ovf, d_busy, d_ovf;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  gcntsrc u_a (.clk(clk), .rst(rst), .inc(inc), .ovf_clr(ovf_clr), .gcnt(a_gcnt),
               .bcnt(a_bcnt), .bklog(a_bklog), .busy(a_busy), .ovf(a_ovf));
  gcntsrc #(.WIDTH(4), .INCW(4), .BKLW(4), .GAP(0)) u_b (.clk(clk), .rst(rst), .inc(inc),
               .ovf_clr(ovf_clr), .gcnt(b_gcnt), .bcnt(b_bcnt), .bklog(b_bklog),
               .busy(b_busy), .ovf(b_ovf));
  gcntsrc #(.GAP(2)) u_c (.clk(clk), .rst(rst), .inc(inc), .ovf_clr(ovf_clr), .gcnt(c_gcnt),
               .bcnt(c_bcnt), .bklog(c_bklog), .busy(c_busy), .ovf(c_ovf));
  gcntsrc #(.GAP(3)) u_d (.clk(clk), .rst(rst), .inc(inc), .ovf_clr(ovf_clr), .gcnt(d_gcnt),
               .bcnt(d_bcnt), .bklog(d_bklog), .busy(d_busy), .ovf(d_ovf));

  // Single-bit-change check on every cycle outside reset
  logic [15:0] pa, pc, pd;
  logic [3:0]  pb;
  always @(negedge clk) begin
    if (!rst) begin
      vectors++;
      if ($countones(pa ^ a_gcnt) > 1) begin errors++; $display("FAIL onebit_a: %h -> %h", pa, a_gcnt); end
      vectors++;
      if ($countones(pb ^ b_gcnt) > 1) begin errors++; $display("FAIL onebit_b: %h -> %h", pb, b_gcnt); end
      vectors++;
      if ($countones(pc ^ c_gcnt) > 1) begin errors++; $display("FAIL onebit_c: %h -> %h", pc, c_gcnt); end
      vectors++;
      if ($countones(pd ^ d_gcnt) > 1) begin errors++; $display("FAIL onebit_d: %h -> %h", pd, d_gcnt); end
    end
    pa = a_gcnt; pb = b_gcnt; pc = c_gcnt; pd = d_gcnt;
  end

  task automatic cyc(input logic [3:0] iv, input logic clr);
    inc = iv;
    ovf_clr = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    inc = '0;
    ovf_clr = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    cyc(4'd13, 1'b0);
    repeat (6) cyc(4'd0, 1'b0);
    vectors++;
    if (a_bklog !== 8'd7 || a_gcnt !== 16'h0005) begin
      errors++; $display("FAIL reset_pre: bklog=%0d gcnt=%h want 7 0005", a_bklog, a_gcnt);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if ({a_gcnt, a_bcnt, a_bklog, a_busy, a_ovf} !== '0) begin
      errors++; $display("FAIL reset_async: gcnt=%h bcnt=%h bklog=%0d busy=%b ovf=%b want all 0",
                         a_gcnt, a_bcnt, a_bklog, a_busy, a_ovf);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) cyc(4'd0, 1'b0);
    vectors++;
    if ({a_gcnt, a_bcnt, a_bklog, a_busy, a_ovf} !== '0) begin
      errors++; $display("FAIL reset_hold: gcnt=%h bcnt=%h bklog=%0d want all 0", a_gcnt, a_bcnt, a_bklog);
    end
  endtask

  task automatic test_burst();
    logic [15:0] exp_g [5];
    exp_g[0] = 16'h1; exp_g[1] = 16'h3; exp_g[2] = 16'h2; exp_g[3] = 16'h6; exp_g[4] = 16'h7;
    do_reset();
    cyc(4'd5, 1'b0);
    vectors++;
    if (a_gcnt !== 16'h0 || a_bklog !== 8'd5 || a_busy !== 1'b1) begin
      errors++; $display("FAIL burst_latency: gcnt=%h bklog=%0d busy=%b want 0 5 1", a_gcnt, a_bklog, a_busy);
    end
    for (int i = 0; i < 5; i++) begin
      cyc(4'd0, 1'b0);
      vectors++;
      if (a_gcnt !== exp_g[i]) begin
        errors++; $display("FAIL burst_seq[%0d]: gcnt=%h want %h", i, a_gcnt, exp_g[i]);
      end
    end
    vectors++;
    if (a_bcnt !== 16'd5 || a_bklog !== 8'd0 || a_busy !== 1'b0) begin
      errors++; $display("FAIL burst_end: bcnt=%0d bklog=%0d busy=%b want 5 0 0", a_bcnt, a_bklog, a_busy);
    end
  endtask

  task automatic test_spacing();
    logic [15:0] exp_b [8];
    exp_b[0] = 0; exp_b[1] = 1; exp_b[2] = 1; exp_b[3] = 1;
    exp_b[4] = 2; exp_b[5] = 2; exp_b[6] = 2; exp_b[7] = 3;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      cyc((i == 0) ? 4'd3 : 4'd0, 1'b0);
      vectors++;
      if (c_bcnt !== exp_b[i]) begin
        errors++; $display("FAIL spacing[%0d]: bcnt=%0d want %0d", i, c_bcnt, exp_b[i]);
      end
    end
    vectors++;
    if (c_gcnt !== 16'h0002 || c_bklog !== 8'd0 || c_busy !== 1'b0) begin
      errors++; $display("FAIL spacing_end: gcnt=%h bklog=%0d busy=%b want 0002 0 0", c_gcnt, c_bklog, c_busy);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    cyc(4'd10, 1'b0);
    cyc(4'd0, 1'b0);
    cyc(4'd7, 1'b0);
    repeat (13) cyc(4'd0, 1'b0);
    vectors++;
    if (b_bcnt !== 4'd15 || b_gcnt !== 4'h8) begin
      errors++; $display("FAIL wrap_top: bcnt=%0d gcnt=%h want 15 8", b_bcnt, b_gcnt);
    end
    cyc(4'd0, 1'b0);
    vectors++;
    if (b_bcnt !== 4'd0 || b_gcnt !== 4'h0) begin
      errors++; $display("FAIL wrap_zero: bcnt=%0d gcnt=%h want 0 0", b_bcnt, b_gcnt);
    end
    cyc(4'd0, 1'b0);
    vectors++;
    if (b_bcnt !== 4'd1 || b_gcnt !== 4'h1 || b_busy !== 1'b0 || b_ovf !== 1'b0) begin
      errors++; $display("FAIL wrap_end: bcnt=%0d gcnt=%h busy=%b ovf=%b want 1 1 0 0",
                         b_bcnt, b_gcnt, b_busy, b_ovf);
    end
  endtask

  task automatic test_overflow();
    int n;
    logic [3:0] prevb;
    do_reset();
    n = 0;
    prevb = b_bcnt;
    for (int i = 0; i < 3; i++) begin
      cyc(4'd15, 1'b0);
      if (b_bcnt != prevb) n++;
      prevb = b_bcnt;
      if (i == 0) begin
        vectors++;
        if (b_ovf !== 1'b0) begin errors++; $display("FAIL ovf_nosat: ovf=%b want 0", b_ovf); end
      end
    end
    vectors++;
    if (b_bklog !== 4'd15 || b_ovf !== 1'b1) begin
      errors++; $display("FAIL ovf_sat: bklog=%0d ovf=%b want 15 1", b_bklog, b_ovf);
    end
    for (int i = 0; i < 40 && b_busy; i++) begin
      cyc(4'd0, 1'b0);
      if (b_bcnt != prevb) n++;
      prevb = b_bcnt;
    end
    vectors++;
    if (n !== 17 || b_busy !== 1'b0 || b_ovf !== 1'b1) begin
      errors++; $display("FAIL ovf_drain: emitted=%0d busy=%b ovf=%b want 17 0 1", n, b_busy, b_ovf);
    end
    cyc(4'd0, 1'b1);
    vectors++;
    if (b_ovf !== 1'b0) begin errors++; $display("FAIL ovf_clr: ovf=%b want 0", b_ovf); end
    cyc(4'd15, 1'b0);
    cyc(4'd15, 1'b1);
    vectors++;
    if (b_ovf !== 1'b1 || b_bklog !== 4'd15) begin
      errors++; $display("FAIL ovf_set_wins: ovf=%b bklog=%0d want 1 15", b_ovf, b_bklog);
    end
  endtask

  task automatic model(input int g, input int iv, input bit clr, inout int bk, inout int gp,
                       inout logic [15:0] b, inout bit ov, inout int drop);
    int stp, s;
    stp = (bk != 0 && gp == 0) ? 1 : 0;
    s = bk + iv - stp;
    if (s > 255) begin
      drop += s - 255;
      bk = 255;
      ov = 1'b1;
    end else begin
      bk = s;
      if (clr) ov = 1'b0;
    end
    b = b + 16'(stp);
    if (stp != 0) gp = g;
    else if (gp > 0) gp--;
  endtask

  task automatic test_random();
    int ma_bk, ma_gp, ma_drop, md_bk, md_gp, md_drop, acc, a_em, d_em, iv;
    logic [15:0] ma_b, md_b, a_pb, d_pb;
    bit ma_ov, md_ov, clr, done;
    do_reset();
    ma_bk = 0; ma_gp = 0; ma_drop = 0; ma_b = 0; ma_ov = 0;
    md_bk = 0; md_gp = 0; md_drop = 0; md_b = 0; md_ov = 0;
    acc = 0; a_em = 0; d_em = 0; a_pb = 0; d_pb = 0;
    done = 1'b0;
    for (int i = 0; i < 1600 && !done; i++) begin
      if (i < 300 && $urandom_range(0, 39) == 0) begin
        do_reset();
        ma_bk = 0; ma_gp = 0; ma_drop = 0; ma_b = 0; ma_ov = 0;
        md_bk = 0; md_gp = 0; md_drop = 0; md_b = 0; md_ov = 0;
        acc = 0; a_em = 0; d_em = 0; a_pb = 0; d_pb = 0;
      end
      iv  = (i < 300 && $urandom_range(0, 2) != 0) ? int'($urandom_range(0, 15)) : 0;
      clr = (i < 300 && $urandom_range(0, 7) == 0);
      acc += iv;
      model(0, iv, clr, ma_bk, ma_gp, ma_b, ma_ov, ma_drop);
      model(3, iv, clr, md_bk, md_gp, md_b, md_ov, md_drop);
      cyc(4'(iv), clr);
      if (a_bcnt != a_pb) a_em++;
      if (d_bcnt != d_pb) d_em++;
      a_pb = a_bcnt; d_pb = d_bcnt;
      vectors++;
      if (a_bcnt !== ma_b || a_gcnt !== (ma_b ^ (ma_b >> 1)) || a_bklog !== 8'(ma_bk) || a_ovf !== ma_ov) begin
        errors++; $display("FAIL rand_a[%0d]: bcnt=%h gcnt=%h bklog=%0d ovf=%b want %h %h %0d %b",
                           i, a_bcnt, a_gcnt, a_bklog, a_ovf, ma_b, ma_b ^ (ma_b >> 1), ma_bk, ma_ov);
      end
      vectors++;
      if (d_bcnt !== md_b || d_gcnt !== (md_b ^ (md_b >> 1)) || d_bklog !== 8'(md_bk) || d_ovf !== md_ov) begin
        errors++; $display("FAIL rand_d[%0d]: bcnt=%h gcnt=%h bklog=%0d ovf=%b want %h %h %0d %b",
                           i, d_bcnt, d_gcnt, d_bklog, d_ovf, md_b, md_b ^ (md_b >> 1), md_bk, md_ov);
      end
      if (i >= 300 && !a_busy && !d_busy) done = 1'b1;
    end
    vectors++;
    if (!done) begin errors++; $display("FAIL rand_timeout: busy_a=%b busy_d=%b want 0 0", a_busy, d_busy); end
    vectors++;
    if (a_em !== acc - ma_drop) begin
      errors++; $display("FAIL score_a: emitted=%0d want %0d", a_em, acc - ma_drop);
    end
    vectors++;
    if (d_em !== acc - md_drop) begin
      errors++; $display("FAIL score_d: emitted=%0d want %0d", d_em, acc - md_drop);
    end
  endtask

  initial begin
    test_reset();
    test_burst();
    test_spacing();
    test_wrap();
    test_overflow();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
